// File: rtl/sensor_conditioner.sv
// -----------------------------------------------------------------------------
// sensor_conditioner
//
// Conditions four raw track-sensor levels for the train-state controller. Each
// channel is handled independently, in four steps:
//   1. A two-flop synchronizer (sync1, sync2).
//   2. An 8-bit debounce counter. A level change is accepted only after sync2
//      has differed from the accepted level for DEBOUNCE consecutive edges.
//   3. Registered one-cycle rise and fall pulses. Each pulse is high in the
//      cycle where sr first shows its new value.
//   4. Optional stuck-high detector, compiled in with the macro
//      SENSOR_STUCK_DETECT_EN. A channel whose sr stays high for STUCK_LIMIT
//      consecutive cycles is latched as faulted. A faulted channel is then
//      held at 0 until reset.
//
// Parameters
//   DEBOUNCE     stable cycles before a level change is accepted (1..255)
//   STUCK_LIMIT  consecutive high cycles before a channel is declared stuck
//                (1..65535); only used with SENSOR_STUCK_DETECT_EN
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous active-low reset
//   sr_raw   in   [4:1] raw asynchronous sensor levels
//   sr       out  [4:1] debounced sensor levels
//   sr_rise  out  [4:1] one-cycle pulse on each 0->1 change of sr
//   sr_fall  out  [4:1] one-cycle pulse on each 1->0 change of sr
//   fault    out  [4:1] sticky stuck-high flags (tied to 0 without the macro)
// -----------------------------------------------------------------------------
module sensor_conditioner #(
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned STUCK_LIMIT = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:1] sr_raw,
    output logic [4:1] sr,
    output logic [4:1] sr_rise,
    output logic [4:1] sr_fall,
    output logic [4:1] fault
);

    // Reject illegal configurations at elaboration time.
    if (DEBOUNCE < 1 || DEBOUNCE > 255) begin : g_bad_debounce
        $error("sensor_conditioner: DEBOUNCE must be in 1..255");
    end
    if (STUCK_LIMIT < 1 || STUCK_LIMIT > 65535) begin : g_bad_stuck_limit
        $error("sensor_conditioner: STUCK_LIMIT must be in 1..65535");
    end

    // Counter value on which a pending change is accepted.
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);

    for (genvar g = 1; g <= 4; g++) begin : g_ch
        logic       sync1_q;
        logic       sync2_q;
        logic       sr_q;
        logic       rise_q;
        logic       fall_q;
        logic       fault_q;
        logic [7:0] db_cnt;
        logic [7:0] db_cnt_next;
        logic       sr_deb;
        logic       sr_next;

        // Debounce rule. Agreement clears the counter. Disagreement counts up.
        // On the DEBOUNCE-th consecutive disagreement the new level is taken
        // and the counter restarts.
        always_comb begin
            sr_deb      = sr_q;
            db_cnt_next = '0;
            if (sync2_q != sr_q) begin
                if (db_cnt == DB_LAST) begin
                    sr_deb = sync2_q;
                end else begin
                    db_cnt_next = db_cnt + 8'd1;
                end
            end
        end

`ifdef SENSOR_STUCK_DETECT_EN
        localparam logic [15:0] STUCK_LAST = 16'(STUCK_LIMIT - 1);

        logic [15:0] stuck_cnt;
        logic        fault_set;

        // The fault latches on the edge where the high count would reach
        // STUCK_LIMIT. sr is forced low on that same edge, so the normal edge
        // logic below emits exactly one fall pulse. No rise is possible while
        // the fault is held.
        assign fault_set = sr_q && !fault_q && (stuck_cnt == STUCK_LAST);
        assign sr_next   = (fault_q || fault_set) ? 1'b0 : sr_deb;

        always_ff @(posedge clk) begin
            if (!reset) begin
                stuck_cnt <= '0;
                fault_q   <= 1'b0;
            end else begin
                if (!sr_q) begin
                    stuck_cnt <= '0;
                end else if (stuck_cnt != '1) begin
                    stuck_cnt <= stuck_cnt + 16'd1;
                end
                if (fault_set) begin
                    fault_q <= 1'b1;
                end
            end
        end
`else
        assign sr_next = sr_deb;
        assign fault_q = 1'b0;
`endif

        always_ff @(posedge clk) begin
            if (!reset) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                sr_q    <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                db_cnt  <= '0;
            end else begin
                sync1_q <= sr_raw[g];
                sync2_q <= sync1_q;
                db_cnt  <= db_cnt_next;
                sr_q    <= sr_next;
                // The pulses are registered alongside sr, so each one appears
                // in the same cycle as the new level.
                rise_q  <= sr_next & ~sr_q;
                fall_q  <= ~sr_next & sr_q;
            end
        end

        assign sr[g]      = sr_q;
        assign sr_rise[g] = rise_q;
        assign sr_fall[g] = fall_q;
        assign fault[g]   = fault_q;
    end

endmodule

// File: tb/tb_sensor_conditioner.sv
module tb_sensor_conditioner;

    localparam int DEB = 4;
    localparam int STK = 16;

    typedef struct packed {
        logic [4:1] sr;
        logic [4:1] rise;
        logic [4:1] fall;
        logic [4:1] fault;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [4:1] sr_raw;
    logic [4:1] sr;
    logic [4:1] sr_rise;
    logic [4:1] sr_fall;
    logic [4:1] fault;

    sensor_conditioner #(
        .DEBOUNCE    (DEB),
        .STUCK_LIMIT (STK)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sr_raw  (sr_raw),
        .sr      (sr),
        .sr_rise (sr_rise),
        .sr_fall (sr_fall),
        .fault   (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    // Reference model state.
    logic [4:1] m_s1, m_s2, m_sr, m_rise, m_fall, m_fault;
    int         m_cnt[4:1];
    int         m_stuck[4:1];

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b, want %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advances the model by one rising edge, using the inputs present at that edge.
    task automatic model_step(input logic [4:1] raw, input logic rst, output exp_t e);
        logic [4:1] nsr;
        logic [4:1] fset;
        nsr  = m_sr;
        fset = '0;
        if (!rst) begin
            m_s1 = '0; m_s2 = '0; m_sr = '0;
            m_rise = '0; m_fall = '0; m_fault = '0;
            for (int i = 1; i <= 4; i++) begin
                m_cnt[i]   = 0;
                m_stuck[i] = 0;
            end
        end else begin
            for (int i = 1; i <= 4; i++) begin
                if (m_s2[i] == m_sr[i]) begin
                    m_cnt[i] = 0;
                end else if (m_cnt[i] == DEB - 1) begin
                    nsr[i]   = m_s2[i];
                    m_cnt[i] = 0;
                end else begin
                    m_cnt[i]++;
                end
`ifdef SENSOR_STUCK_DETECT_EN
                fset[i] = m_sr[i] && !m_fault[i] && (m_stuck[i] + 1 == STK);
                if (m_sr[i]) begin
                    if (m_stuck[i] < 65535) m_stuck[i]++;
                end else begin
                    m_stuck[i] = 0;
                end
                if (m_fault[i] || fset[i]) nsr[i] = 1'b0;
`endif
            end
            m_rise  = nsr & ~m_sr;
            m_fall  = m_sr & ~nsr;
            m_sr    = nsr;
            m_fault = m_fault | fset;
            m_s2    = m_s1;
            m_s1    = raw;
        end
        e.sr    = m_sr;
        e.rise  = m_rise;
        e.fall  = m_fall;
        e.fault = m_fault;
    endtask

    // Drives one cycle of stimulus, queues the model's prediction, and
    // compares it with the DUT outputs just after the edge.
    task automatic step(input logic [4:1] raw, input logic rst);
        exp_t e;
        sr_raw = raw;
        reset  = rst;
        model_step(raw, rst, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb_sr",    sr,      e.sr);
        check("sb_rise",  sr_rise, e.rise);
        check("sb_fall",  sr_fall, e.fall);
        check("sb_fault", fault,   e.fault);
    endtask

    task automatic hold(input logic [4:1] raw, input int n);
        for (int k = 0; k < n; k++) step(raw, 1'b1);
    endtask

    initial begin
        sr_raw = '0;
        reset  = 1'b0;
        m_s1 = '0; m_s2 = '0; m_sr = '0;
        m_rise = '0; m_fall = '0; m_fault = '0;
        for (int i = 1; i <= 4; i++) begin
            m_cnt[i]   = 0;
            m_stuck[i] = 0;
        end

        // Reset held with all raw inputs high, then released.
        for (int k = 0; k < 2; k++) begin
            step(4'b1111, 1'b0);
            check("rst_sr",    sr,      4'b0000);
            check("rst_rise",  sr_rise, 4'b0000);
            check("rst_fall",  sr_fall, 4'b0000);
            check("rst_fault", fault,   4'b0000);
        end
        for (int k = 1; k <= 5; k++) begin
            step(4'b1111, 1'b1);
            check("rel_wait_sr", sr, 4'b0000);
        end
        step(4'b1111, 1'b1);
        check("rel_sr",   sr,      4'b1111);
        check("rel_rise", sr_rise, 4'b1111);
        step(4'b0000, 1'b1);
        check("rel_rise_one", sr_rise, 4'b0000);
        hold(4'b0000, 8);
        check("rel_back_low", sr, 4'b0000);

        // Single-channel change: the rise appears on the 6th edge, for one cycle.
        for (int k = 1; k <= 5; k++) begin
            step(4'b0001, 1'b1);
            check("basic_wait_sr", sr, 4'b0000);
        end
        step(4'b0001, 1'b1);
        check("basic_sr",   sr,      4'b0001);
        check("basic_rise", sr_rise, 4'b0001);
        check("basic_fall", sr_fall, 4'b0000);
        step(4'b0001, 1'b1);
        check("basic_rise_one", sr_rise, 4'b0000);
        check("basic_sr_hold",  sr,      4'b0001);
        hold(4'b0000, 8);

        // Glitch rejection: three high cycles on channel 2 are filtered out.
        for (int k = 0; k < 13; k++) begin
            step((k < 3) ? 4'b0010 : 4'b0000, 1'b1);
            check("glitch_sr",   sr,      4'b0000);
            check("glitch_rise", sr_rise, 4'b0000);
            check("glitch_fall", sr_fall, 4'b0000);
        end

        // Simultaneous change on all channels.
        hold(4'b0011, 8);
        check("simul_pre_sr", sr, 4'b0011);
        for (int k = 1; k <= 5; k++) begin
            step(4'b1100, 1'b1);
            check("simul_wait_sr", sr, 4'b0011);
        end
        step(4'b1100, 1'b1);
        check("simul_sr",   sr,      4'b1100);
        check("simul_rise", sr_rise, 4'b1100);
        check("simul_fall", sr_fall, 4'b0011);
        hold(4'b0000, 8);

        // Reset in mid-debounce aborts the pending change.
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b0);
        check("midrst_sr",   sr,      4'b0000);
        check("midrst_rise", sr_rise, 4'b0000);
        for (int k = 1; k <= 5; k++) begin
            step(4'b0100, 1'b1);
            check("midrst_wait_sr",   sr,      4'b0000);
            check("midrst_wait_rise", sr_rise, 4'b0000);
        end
        step(4'b0100, 1'b1);
        check("midrst_sr_rise", sr,      4'b0100);
        check("midrst_rise_p",  sr_rise, 4'b0100);
        hold(4'b0000, 8);

        // Random held patterns, checked only against the model.
        for (int k = 0; k < 20; k++) begin
            hold(4'($urandom_range(0, 15)), int'($urandom_range(1, 9)));
        end

        // Stuck-high channel 4.
        step(4'b0000, 1'b0);
        hold(4'b1000, 6);
        check("stuck_rise_sr", sr, 4'b1000);
`ifdef SENSOR_STUCK_DETECT_EN
        for (int k = 1; k <= 15; k++) begin
            step(4'b1000, 1'b1);
            check("stuck_wait_sr",    sr,    4'b1000);
            check("stuck_wait_fault", fault, 4'b0000);
        end
        step(4'b1000, 1'b1);
        check("stuck_fault", fault,   4'b1000);
        check("stuck_sr",    sr,      4'b0000);
        check("stuck_fall",  sr_fall, 4'b1000);
        for (int k = 0; k < 30; k++) begin
            step(((k / 7) % 2 == 0) ? 4'b0000 : 4'b1000, 1'b1);
            check("stuck_fault_sticky", fault,      4'b1000);
            check("stuck_sr_held",      sr,         4'b0000);
            check("stuck_no_rise",      sr_rise,    4'b0000);
        end
        step(4'b0000, 1'b0);
        check("stuck_fault_cleared", fault, 4'b0000);
`else
        hold(4'b1000, 40);
        check("nostuck_sr",    sr,    4'b1000);
        check("nostuck_fault", fault, 4'b0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
